// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared access-size encodings and FSM state type for the
//            wait-state data memory.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Request sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane
// Purpose  : Combinational lane logic: merges store data into the addressed
//            byte/half lane of a word and extracts/extends load data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, merge store data into it, extend load data
  always_comb begin
    o_merged = i_old;
    o_load   = i_old;
    w_byte   = i_old[{i_lane, 3'b000} +: 8];
    w_half   = i_old[{i_lane[1], 4'b0000} +: 16];
    case (i_size)
      SZ_BYTE: begin
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        o_load = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        // Word access (the illegal size never commits a write or data)
        o_merged = i_wdata;
        o_load   = i_old;
      end
    endcase
  end

endmodule : dmem_lane
`default_nettype wire

// File: rtl/dmem_wait.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait
// Purpose  : Single-outstanding data memory with a fixed number of wait
//            cycles between request accept and commit, valid/ready response
//            handshake, and error reporting for illegal/misaligned/OOB access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         c_idx_w    = $clog2(DEPTH);
  // Counter preload so that WAIT lasts exactly LATENCY cycles
  localparam logic [3:0] c_lat_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;

  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_commit;
  logic                w_src_we;
  logic [1:0]          w_src_size;
  logic                w_src_unsigned;
  logic [ADDR_W-1:0]   w_src_addr;
  logic [31:0]         w_src_wdata;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_oob;
  logic                w_err;
  logic [31:0]         w_old;
  logic [31:0]         w_merged;
  logic [31:0]         w_load;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_commit = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                    (w_accept && (LATENCY == 0));

  // With zero latency the commit happens on the accept edge itself, so the
  // live request fields are used instead of the (not yet loaded) latches.
  assign w_src_we       = (r_state == ST_IDLE) ? req_we       : r_we;
  assign w_src_size     = (r_state == ST_IDLE) ? req_size     : r_size;
  assign w_src_unsigned = (r_state == ST_IDLE) ? req_unsigned : r_unsigned;
  assign w_src_addr     = (r_state == ST_IDLE) ? req_addr     : r_addr;
  assign w_src_wdata    = (r_state == ST_IDLE) ? req_wdata    : r_wdata;

  assign w_idx = w_src_addr[c_idx_w+1:2];
  assign w_old = r_mem[w_idx];

  generate
    if (ADDR_W > c_idx_w + 2) begin : g_oob
      assign w_oob = |w_src_addr[ADDR_W-1:c_idx_w+2];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  // Classify the access: illegal size, misalignment or out-of-range word
  always_comb begin
    w_err = w_oob;
    case (w_src_size)
      SZ_ILL:  w_err = 1'b1;
      SZ_HALF: if (w_src_addr[0]) w_err = 1'b1;
      SZ_WORD: if (w_src_addr[1:0] != 2'b00) w_err = 1'b1;
      default: ;
    endcase
  end

  dmem_lane u_lane (
    .i_size     (w_src_size),
    .i_unsigned (w_src_unsigned),
    .i_lane     (w_src_addr[1:0]),
    .i_wdata    (w_src_wdata),
    .i_old      (w_old),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags follow the state directly
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Wait-cycle counter: preloaded on accept, counts down through WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_lat_load;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Latch request fields at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Capture response at commit; stores and errors return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_src_we) ? 32'd0 : w_load;
    end
  end

  // Memory array: cleared on reset, written at commit of a legal store
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_commit && w_src_we && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

endmodule : dmem_wait
`default_nettype wire

// File: tb/tb_dmem_wait.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wait
// Purpose  : Self-checking bench for dmem_wait (LATENCY=2, DEPTH=1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wait;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int ADDR_W  = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [26];

  dmem_wait #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  // One full transaction; called 1 time unit after a rising edge in IDLE.
  // lat counts cycles after the accepting edge until resp_valid is seen.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    // we, size, uns, addr, wdata, expected rdata, expected err
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 32'h10,   32'h12345678, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'h12345678, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h13,   32'h000000AB, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        32'hFFFFFFAB, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b1, 32'h13,   32'h0,        32'h000000AB, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hAB345678, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        32'h00000000, 1'b1};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h00000000, 1'b1};
    tbl[8]  = '{1'b1, 2'b11, 1'b0, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hAB345678, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h1000, 32'h55555555, 32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h00000000, 1'b0};
    tbl[13] = '{1'b1, 2'b01, 1'b0, 32'h12,   32'h1234BEEF, 32'h00000000, 1'b0};
    tbl[14] = '{1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[15] = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h0000BEEF, 1'b0};
    tbl[16] = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hBEEF5678, 1'b0};
    tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hFFFFFF7F, 32'h00000000, 1'b0};
    tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h0000007F, 1'b0};
    tbl[19] = '{1'b0, 2'b00, 1'b0, 32'h12,   32'h0,        32'h00000000, 1'b1};
    tbl[20] = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'h0000567F, 1'b0};
    tbl[21] = '{1'b0, 2'b00, 1'b1, 32'h10,   32'h0,        32'hBEEF567F, 1'b0};
    tbl[22] = '{1'b0, 2'b10, 1'b1, 32'h11,   32'h0,        32'h00000056, 1'b0};
    tbl[23] = '{1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        32'hFFFFFFEF, 1'b0};
    tbl[24] = '{1'b1, 2'b01, 1'b0, 32'h11,   32'h0000FFFF, 32'h00000000, 1'b1};
    tbl[25] = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hBEEF567F, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset req_ready",  {31'd0, req_ready},  32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata,          32'd0);
    chk("reset resp_err",   {31'd0, resp_err},   32'd0);

    // Table-driven transactions
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("v%0d req_ready", i), {31'd0, req_ready}, 32'd1);
      xact(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rd, er, lat);
      chk($sformatf("v%0d rdata", i),   rd,               tbl[i].rd);
      chk($sformatf("v%0d err", i),     {31'd0, er},      {31'd0, tbl[i].er});
      chk($sformatf("v%0d latency", i), 32'(lat),         32'(LATENCY + 1));
    end

    // Backpressure: response held for 5 cycles with resp_ready low
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp wait req_ready", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d rdata", k),      resp_rdata,          32'hBEEF567F);
      chk($sformatf("bp%0d req_ready", k),  {31'd0, req_ready},  32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp release resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp release req_ready",  {31'd0, req_ready},  32'd1);

    // Reset during WAIT discards a pending store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstwait in wait req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait req_ready",  {31'd0, req_ready},  32'd1);
    chk("rstwait resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstwait no late resp", {31'd0, resp_valid}, 32'd0);
    xact(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rstwait load 0x20",     rd,          32'd0);
    chk("rstwait load 0x20 err", {31'd0, er}, 32'd0);
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rstwait mem cleared 0x10", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dmem_wait
`default_nettype wire

// File: doc/dmem_wait.md
DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between accept and commit, range 0..15.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block can accept a request.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-010 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  consumer takes the response.
REQ-015 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 SHALL have port resp_err  out  1  request was illegal, misaligned or out of range.

Function
REQ-017 SHALL run an FSM with states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE and SHALL accept a request on a clk edge with req_valid&req_ready, latching all req_* fields.
REQ-019 SHALL move IDLE->WAIT on accept and count LATENCY cycles in WAIT; if LATENCY=0, SHALL move IDLE->RESP directly.
REQ-020 SHALL commit on the WAIT->RESP (or IDLE->RESP) edge: perform any store, capture resp_rdata and resp_err.
REQ-021 SHALL assert resp_valid exactly LATENCY+1 cycles after the accepting edge and hold it, with resp_rdata/resp_err stable, until resp_ready=1.
REQ-022 SHALL return RESP->IDLE on an edge with resp_ready=1; the next request is accepted no earlier than the following edge.
REQ-023 SHALL flag resp_err for any of: size 11; half with addr[0]=1; word with addr[1:0]!=00; addr[ADDR_W-1:2] >= DEPTH.
REQ-024 SHALL suppress the memory write on error and return resp_rdata=0.
REQ-025 SHALL index the word as addr[log2(DEPTH)+1:2], byte lane k=addr[1:0] at bits [8k+7:8k] (little-endian), half lane addr[1] at bits [16*addr[1]+15:16*addr[1]].
REQ-026 SHALL write only the addressed lane(s); other bytes of the word keep their value.
REQ-027 SHALL extend byte and half loads to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-028 SHALL read the memory value as of the commit edge, before that edge's own write.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, enter IDLE, clear the wait counter, drive resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=1 from the next cycle.
REQ-030 SHALL clear all memory words to 0 on rst and at time zero.
REQ-031 SHALL discard an accepted but uncommitted request when rst arrives in WAIT; no write occurs.
REQ-032 SHALL give rst priority over accept, commit and resp_ready on the same edge.

Structure
REQ-033 SHALL place the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state type in shared package dmem_pkg.
REQ-034 SHALL put lane select, write merge and load extension in one combinational sub-module, dmem_lane.

Verification
REQ-035 SHALL check LATENCY=2: store word 0x12345678 to addr 0x10, then load word from 0x10 -> resp_valid 3 cycles after each accept; rdata 0x12345678.
REQ-036 SHALL check a byte store of 0xAB to 0x13, then loads from 0x13 -> signed load gives 0xFFFFFFAB, unsigned load gives 0x000000AB; a word load from 0x10 gives 0xAB345678.
REQ-037 SHALL check a half load from 0x11 and a request with size 11 -> resp_err=1 and rdata 0; a store to 0x10 with size 11 leaves memory unchanged.
REQ-038 SHALL check an address of DEPTH*4 -> resp_err=1 and no write.
REQ-039 SHALL check backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0 throughout.
REQ-040 SHALL check rst asserted in WAIT of a store of 0xFFFFFFFF to 0x20 -> word at 0x20 reads 0; req_ready=1 on the cycle after rst.
